// File: rtl/encoder_8_3_seq.sv
// encoder_8_3_seq: sequential 8-to-3 priority encoder.
// Latches request events on eight lines, then offers the index of the
// highest pending line over a valid/ready handshake.
//
// EDGE_MODE = 1 : a 0->1 transition on in[i] is one event.
// EDGE_MODE = 0 : every cycle with in[i] high is an event.
//
// Build option ENC_OVF_EN: when defined, `overflow` flags an event on a line
// that was already pending (edge mode only) and `clr_ovf` clears it; when
// undefined, `overflow` is tied low and `clr_ovf` is ignored.
module encoder_8_3_seq #(
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       overflow,
  input  logic       clr_ovf
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] in_q;
  logic [7:0] ev;
  logic [7:0] clr;
  logic [7:0] pending_nx;
  logic [2:0] top_idx;
  logic [2:0] out_nx;
  logic       valid_nx;
  logic       accept;

  // Event detection: rising edges or raw levels depending on EDGE_MODE.
  always_comb begin
    ev = (EDGE_MODE != 0) ? (in & ~in_q) : in;
  end

  // Index of the highest set bit of the registered pending vector.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pending[i]) top_idx = i[2:0];
    end
  end

  // FSM next state and next registered outputs; out only changes on a load in IDLE.
  always_comb begin
    state_nx = state;
    out_nx   = out;
    valid_nx = valid;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (pending != '0) begin
          out_nx   = top_idx;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          accept   = 1'b1;
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  // Pending update: a new event on a bit outweighs its clear on the accept edge.
  always_comb begin
    clr        = accept ? (8'b0000_0001 << out) : '0;
    pending_nx = ev | (pending & ~clr);
  end

  // State, handshake outputs, pending vector and input history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out     <= '0;
      valid   <= 1'b0;
      pending <= '0;
      in_q    <= '0;
    end else begin
      state   <= state_nx;
      out     <= out_nx;
      valid   <= valid_nx;
      pending <= pending_nx;
      in_q    <= in;
    end
  end

`ifdef ENC_OVF_EN
  logic ovf_set;

  // An event hitting a pending bit that is not being accepted this edge.
  always_comb begin
    ovf_set = (EDGE_MODE != 0) && ((ev & pending & ~clr) != '0);
  end

  // Sticky overflow flag; a new overflow outweighs clr_ovf on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;

  assign overflow       = 1'b0;
  assign unused_clr_ovf = clr_ovf;
`endif

endmodule
